// File: rtl/dec_pipe.sv
// Elastic decode-to-execute pipeline buffer: a DEPTH-entry valid/ready FIFO.
// It presents a no-op payload while empty and supports a single-cycle flush.
module dec_pipe #(
    parameter int               WIDTH       = 32,
    parameter int               DEPTH       = 2,
    parameter logic [WIDTH-1:0] NOP         = WIDTH'(32'h00000033),
    parameter int               RST_BUBBLES = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_vld,
    output logic                       o_rdy,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_flush,
    output logic                       o_vld,
    input  logic                       i_rdy,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_bubble
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BW = (RST_BUBBLES > 0) ? $clog2(RST_BUBBLES + 1) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp;
    logic [CW-1:0]    count;
    logic [BW-1:0]    bubble_cnt;
    logic             push;
    logic             pop;

    // Pointers wrap explicitly at DEPTH-1, so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign o_rdy    = (count < CW'(DEPTH)) && (bubble_cnt == '0);
    assign o_vld    = (count != '0);
    assign o_bubble = (bubble_cnt != '0);
    assign o_count  = count;
    assign o_data   = o_vld ? mem[rp] : NOP;
    assign push     = i_vld && o_rdy;
    assign pop      = o_vld && i_rdy;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wp         <= '0;
            rp         <= '0;
            count      <= '0;
            bubble_cnt <= BW'(RST_BUBBLES);
        end else begin
            if (bubble_cnt != '0) begin
                bubble_cnt <= bubble_cnt - BW'(1);
            end
            if (i_flush) begin
                wp    <= '0;
                rp    <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    wp <= ptr_next(wp);
                end
                if (pop) begin
                    rp <= ptr_next(rp);
                end
                if (push && !pop) begin
                    count <= count + CW'(1);
                end else if (pop && !push) begin
                    count <= count - CW'(1);
                end
            end
        end
    end

    // Storage is deliberately left unreset; o_data masks it with NOP while empty.
    always_ff @(posedge i_clk) begin
        if (!i_rst && !i_flush && push) begin
            mem[wp] <= i_data;
        end
    end

endmodule
